sfp_ctrl: RTL

SFP_CTRL -- requirements
Module: sfp_ctrl

---
 rtl/sfp_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sfp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sfp_ctrl
// Description : Sequencer for a single sfp (signed partial-sum) accumulator.
//               One run reads `len` samples from an input buffer starting at
//               `base_addr` (wrapping modulo 2^addr_bw). Each sample is
//               streamed into the sfp with acc=1. Relu is optionally applied,
//               then the sfp output is captured into `result`.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   SFP_CTRL_RELU_EN  defined   -> RELU state present, latency len+3
//                     undefined -> no RELU state, relu_mode ignored,
//                                  sfp_relu tied 0, latency len+2
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   request one run (sampled only in IDLE)
//   base_addr    in   first buffer address of the run        [addr_bw]
//   len          in   number of samples to accumulate (0..15) [4]
//   relu_mode    in   apply relu at end of run
//   mem_rd       out  buffer read strobe
//   mem_addr     out  buffer read address                    [addr_bw]
//   mem_data     in   signed read data, valid cycle after rd [bw]
//   sfp_clr      out  clear sfp partial sum (also high during reset)
//   sfp_in       out  sample to sfp, 0 whenever sfp_acc=0    [bw]
//   sfp_acc      out  sfp accumulate enable
//   sfp_relu     out  sfp relu enable
//   sfp_out      in   registered sfp output                  [psum_bw]
//   result       out  captured run result                    [psum_bw]
//   result_valid out  1-cycle pulse when result updated by a run
//   done         out  1-cycle pulse at end of every accepted start
//   busy         out  high in every state except IDLE
// ============================================================================
module sfp_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int addr_bw = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [3:0]         len,
    input  logic               relu_mode,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    input  logic [bw-1:0]      mem_data,
    output logic               sfp_clr,
    output logic [bw-1:0]      sfp_in,
    output logic               sfp_acc,
    output logic               sfp_relu,
    input  logic [psum_bw-1:0] sfp_out,
    output logic [psum_bw-1:0] result,
    output logic               result_valid,
    output logic               done,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACC     = 3'd2,
`ifdef SFP_CTRL_RELU_EN
        S_RELU    = 3'd3,
`endif
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [addr_bw-1:0]   base_q;
    logic [3:0]           len_q;
    // Index of the sample being accumulated in ACC (1..len); 0 in CLEAR so
    // that base_q + cnt_q is also the CLEAR-cycle read address.
    logic [3:0]           cnt_q, cnt_d;
    logic [psum_bw-1:0]   result_q;
    logic                 w_load;
    logic                 w_capture;

`ifdef SFP_CTRL_RELU_EN
    logic                 relu_q;
`else
    // relu_mode has no function in this build; the name marks it as
    // intentionally unconsumed.
    logic                 w_unused_relu_mode;
    assign w_unused_relu_mode = relu_mode;
`endif

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        // The sfp partial sum is held clear for as long as reset is high,
        // independent of the state register.
        sfp_clr      = reset;
        sfp_acc      = 1'b0;
        sfp_in       = '0;
        sfp_relu     = 1'b0;
        done         = 1'b0;
        result_valid = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    cnt_d  = 4'd0;
                    // An empty run skips the datapath entirely but still
                    // reports completion.
                    state_d = (len == 4'd0) ? S_DONE : S_CLEAR;
                end
            end

            S_CLEAR: begin
                sfp_clr  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = base_q;
                cnt_d    = 4'd1;
                state_d  = S_ACC;
            end

            S_ACC: begin
                // mem_data carries the sample read on the previous cycle
                // (address base+cnt-1); prefetch the next one meanwhile.
                sfp_acc = 1'b1;
                sfp_in  = mem_data;
                if (cnt_q < len_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = base_q + addr_bw'(cnt_q);
                end
                if (cnt_q == len_q) begin
`ifdef SFP_CTRL_RELU_EN
                    state_d = S_RELU;
`else
                    state_d = S_CAPTURE;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

`ifdef SFP_CTRL_RELU_EN
            S_RELU: begin
                sfp_relu = relu_q;
                state_d  = S_CAPTURE;
            end
`endif

            S_CAPTURE: begin
                // sfp_out already reflects the last acc/relu update.
                w_capture = 1'b1;
                state_d   = S_DONE;
            end

            S_DONE: begin
                done         = 1'b1;
                result_valid = (len_q != 4'd0);
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and run-context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef SFP_CTRL_RELU_EN
            relu_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Run parameters are frozen at acceptance so the caller may
            // change the inputs freely while the run is in flight.
            if (w_load) begin
                base_q <= base_addr;
                len_q  <= len;
`ifdef SFP_CTRL_RELU_EN
                relu_q <= relu_mode;
`endif
            end
            if (w_capture) begin
                result_q <= sfp_out;
            end
        end
    end

    assign result = result_q;

endmodule
`default_nettype wire
